id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  decode slot holds a real instruction.
REQ-004 id_pc  in  32  decode PC.
REQ-005 id_rs1, id_rs2, id_rd  in  5 each  decoded register indices.
REQ-006 id_usesRs1, id_usesRs2  in  1 each  instruction reads rs1/rs2.
REQ-007 id_rs1Data, id_rs2Data, id_imm  in  32 each  register-file read data, immediate.
REQ-008 id_regWrite, id_memRead, id_memWrite  in  1 each; id_aluOp  in  4.
REQ-009 wbRw  in  1; wbRd  in  5; wbData  in  32  writeback port in the same cycle.
REQ-010 flush  in  1  taken branch/jump resolved in EX; kill ID and ID/EX.
REQ-011 exMemStall  in  1  downstream hold request.
REQ-012 ex_valid, ex_regWrite, ex_memRead, ex_memWrite  out  1 each  registered controls.
REQ-013 ex_pc, ex_rs1Data, ex_rs2Data, ex_imm  out  32 each; ex_rs1, ex_rs2, ex_rd  out  5 each; ex_aluOp  out  4.
REQ-014 holdIfId  out  1  combinational: IF PC and IF/ID register must not advance.
REQ-015 loadUseHazard  out  1  combinational load-use detect.

Function
REQ-016 Hazard = ex_valid & ex_memRead & ex_rd!=0 & id_valid & ((id_usesRs1 & id_rs1==ex_rd) | (id_usesRs2 & id_rs2==ex_rd)); loadUseHazard SHALL equal hazard & ~flush.
REQ-017 holdIfId SHALL equal (loadUseHazard | exMemStall) & ~flush.
REQ-018 Per-edge priority SHALL be rst > flush > exMemStall > loadUseHazard > load.
REQ-019 flush: ex_valid and all ex_ control bits SHALL clear next cycle; datapath fields don't-care.
REQ-020 exMemStall (no flush): every ex_ register SHALL hold its value.
REQ-021 loadUseHazard (no stall/flush): a bubble (ex_valid=0, controls 0) SHALL be loaded; ID instruction re-presented next cycle, then loaded.
REQ-022 Load: all id_ fields SHALL register with latency one cycle; controls AND-ed with id_valid.
REQ-023 WB bypass: if wbRw & wbRd!=0 & wbRd==id_rs1, ex_rs1Data SHALL capture wbData instead of id_rs1Data; same for rs2.
REQ-024 ex_regWrite/ex_memRead/ex_memWrite SHALL never be 1 while ex_valid=0.
REQ-025 Register x0: ex_rd=0 with ex_regWrite=1 is legal; no hazard or bypass SHALL key on index 0.

Reset
REQ-026 rst SHALL clear every ex_ output to 0 on the next edge, overriding flush/stall.
REQ-027 holdIfId and loadUseHazard SHALL be 0 in the cycle after reset (ex_valid=0).
REQ-028 rst asserted mid-stall SHALL drop the pending bubble/hold; no state survives.

Configuration
REQ-029 Macro LOAD_USE_STALL_EN: defined -> REQ-016/021 active.
REQ-030 Undefined -> loadUseHazard tied 0, holdIfId = exMemStall & ~flush, no bubbles; compiler must schedule load-use gaps.

Verification
REQ-031 Reset: rst=1 two cycles with id_valid=1 -> all ex_ outputs 0, holdIfId=0.
REQ-032 Load-use: EX holds lw x5 (memRead=1, rd=5); ID add x6,x5,x1 -> loadUseHazard=1, holdIfId=1, next cycle ex_valid=0, following cycle ex_rd=6, ex_rs1=5.
REQ-033 Flush beats hazard: same as 032 plus flush=1 -> loadUseHazard=0, holdIfId=0, next ex_valid=0.
REQ-034 Stall: exMemStall=1 three cycles with ex_pc=0x100 -> ex_pc stays 0x100, holdIfId=1 throughout.
REQ-035 WB bypass: wbRw=1, wbRd=7, wbData=0xDEADBEEF, id_rs2=7, id_rs2Data=0 -> ex_rs2Data=0xDEADBEEF; wbRd=0 -> no bypass.
REQ-036 Macro off: repeat 032 -> loadUseHazard=0, lw then add loaded back-to-back.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline boundary bundle: decode-side inputs, writeback port,
// flush/stall controls, registered EX-side fields and the hazard outputs.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_usesRs1;
  logic        id_usesRs2;
  logic [31:0] id_rs1Data;
  logic [31:0] id_rs2Data;
  logic [31:0] id_imm;
  logic        id_regWrite;
  logic        id_memRead;
  logic        id_memWrite;
  logic [3:0]  id_aluOp;

  logic        wbRw;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  logic        flush;
  logic        exMemStall;

  logic        ex_valid;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1Data;
  logic [31:0] ex_rs2Data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_aluOp;

  logic        holdIfId;
  logic        loadUseHazard;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_usesRs1, id_usesRs2,
           id_rs1Data, id_rs2Data, id_imm, id_regWrite, id_memRead,
           id_memWrite, id_aluOp, wbRw, wbRd, wbData, flush, exMemStall,
    input  ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_pc,
           ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_aluOp,
           holdIfId, loadUseHazard
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_usesRs1, id_usesRs2,
           id_rs1Data, id_rs2Data, id_imm, id_regWrite, id_memRead,
           id_memWrite, id_aluOp, wbRw, wbRd, wbData, flush, exMemStall,
    output ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_pc,
           ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_aluOp,
           holdIfId, loadUseHazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, downstream stall, writeback bypass
// and optional load-use interlock.
// Optional feature macro: LOAD_USE_STALL_EN (defined -> load-use detection
// inserts bubbles; undefined -> no interlock, software schedules the gap).
module id_ex_stage (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;

  logic load_use;
  logic byp_rs1;
  logic byp_rs2;

`ifdef LOAD_USE_STALL_EN
  logic hazard;

  // Load in EX whose destination is read by the instruction in ID; x0 never matches.
  always_comb begin
    hazard = valid_q & mem_read_q & (rd_q != 5'd0) & bus.id_valid &
             ((bus.id_usesRs1 & (bus.id_rs1 == rd_q)) |
              (bus.id_usesRs2 & (bus.id_rs2 == rd_q)));
  end

  assign load_use = hazard & ~bus.flush;
`else
  // Source-use flags only feed the interlock, which is compiled out here.
  logic unused_uses;
  assign unused_uses = &{1'b0, bus.id_usesRs1, bus.id_usesRs2};
  assign load_use    = 1'b0;
`endif

  assign bus.loadUseHazard = load_use;
  assign bus.holdIfId      = (load_use | bus.exMemStall) & ~bus.flush;

  // Writeback in the same cycle as the register-file read wins over stale read data.
  assign byp_rs1 = bus.wbRw & (bus.wbRd != 5'd0) & (bus.wbRd == bus.id_rs1);
  assign byp_rs2 = bus.wbRw & (bus.wbRd != 5'd0) & (bus.wbRd == bus.id_rs2);

  // Next-state select: flush > stall > bubble > load; datapath held when not loading.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    alu_op_d    = alu_op_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!bus.exMemStall) begin
      if (load_use) begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end else begin
        valid_d     = bus.id_valid;
        reg_write_d = bus.id_regWrite & bus.id_valid;
        mem_read_d  = bus.id_memRead & bus.id_valid;
        mem_write_d = bus.id_memWrite & bus.id_valid;
        alu_op_d    = bus.id_aluOp;
        pc_d        = bus.id_pc;
        rs1_d       = bus.id_rs1;
        rs2_d       = bus.id_rs2;
        rd_d        = bus.id_rd;
        rs1_data_d  = byp_rs1 ? bus.wbData : bus.id_rs1Data;
        rs2_data_d  = byp_rs2 ? bus.wbData : bus.id_rs2Data;
        imm_d       = bus.id_imm;
      end
    end
  end

  // Pipeline register; synchronous reset overrides flush and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_op_q    <= 4'd0;
      pc_q        <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_op_q    <= alu_op_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_regWrite = reg_write_q;
  assign bus.ex_memRead  = mem_read_q;
  assign bus.ex_memWrite = mem_write_q;
  assign bus.ex_aluOp    = alu_op_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_rs1Data  = rs1_data_q;
  assign bus.ex_rs2Data  = rs2_data_q;
  assign bus.ex_imm      = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX contents,
// one task per scenario. Builds with or without LOAD_USE_STALL_EN.
module tb_id_ex_stage;

  logic clk;
  logic rst;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
  } ex_t;

  typedef struct {
    ex_t  e;
    logic ctrl_only;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  function automatic ex_t obs();
    ex_t o;
    o = '{v: bus.ex_valid, rw: bus.ex_regWrite, mr: bus.ex_memRead,
          mw: bus.ex_memWrite, alu: bus.ex_aluOp, rs1: bus.ex_rs1,
          rs2: bus.ex_rs2, rd: bus.ex_rd, pc: bus.ex_pc,
          d1: bus.ex_rs1Data, d2: bus.ex_rs2Data, imm: bus.ex_imm};
    return o;
  endfunction

  function automatic ex_t mk(logic v, logic rw, logic mr, logic mw,
                             logic [3:0] alu, logic [4:0] rs1, logic [4:0] rs2,
                             logic [4:0] rd, logic [31:0] pc, logic [31:0] d1,
                             logic [31:0] d2, logic [31:0] imm);
    ex_t e;
    e = '{v: v, rw: rw, mr: mr, mw: mw, alu: alu, rs1: rs1, rs2: rs2, rd: rd,
          pc: pc, d1: d1, d2: d2, imm: imm};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                     logic [4:0] rd, logic u1, logic u2, logic [31:0] d1,
                     logic [31:0] d2, logic [31:0] imm, logic rw, logic mr,
                     logic mw, logic [3:0] alu);
    bus.id_valid    = v;
    bus.id_pc       = pc;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_usesRs1  = u1;
    bus.id_usesRs2  = u2;
    bus.id_rs1Data  = d1;
    bus.id_rs2Data  = d2;
    bus.id_imm      = imm;
    bus.id_regWrite = rw;
    bus.id_memRead  = mr;
    bus.id_memWrite = mw;
    bus.id_aluOp    = alu;
  endtask

  task automatic idle();
    drv(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b0, 4'd0);
    bus.wbRw = 1'b0; bus.wbRd = 5'd0; bus.wbData = 32'd0;
    bus.flush = 1'b0; bus.exMemStall = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hAAAA_0001,
        32'hBBBB_0002, 32'h7, 1'b1, 1'b1, 1'b1, 4'h5);
    bus.wbRw = 1'b0; bus.wbRd = 5'd0; bus.wbData = 32'd0;
    bus.flush = 1'b1; bus.exMemStall = 1'b1;
    tick();
    bus.flush = 1'b0; bus.exMemStall = 1'b0;
    tick();
    n_chk++;
    if (obs() !== ex_t'(0)) begin
      n_fail++;
      $display("FAIL reset_ex got=%h exp=%h", obs(), ex_t'(0));
    end
    n_chk++;
    if (bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold got=%b exp=0", bus.holdIfId);
    end
    n_chk++;
    if (bus.loadUseHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lu got=%b exp=0", bus.loadUseHazard);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load();
    sb_t s;
    ex_t o;
    idle();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          drv(1'b1, 32'h4, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h1111_1111,
              32'h2222_2222, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
          s.e = mk(1, 1, 0, 0, 4'h0, 5'd1, 5'd2, 5'd3, 32'h4, 32'h1111_1111,
                   32'h2222_2222, 32'h0);
        end
        1: begin
          drv(1'b1, 32'h8, 5'd4, 5'd9, 5'd0, 1'b0, 1'b0, 32'h1000,
              32'hCAFE_F00D, 32'h10, 1'b0, 1'b0, 1'b1, 4'h2);
          s.e = mk(1, 0, 0, 1, 4'h2, 5'd4, 5'd9, 5'd0, 32'h8, 32'h1000,
                   32'hCAFE_F00D, 32'h10);
        end
        2: begin
          drv(1'b0, 32'hC, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0, 32'h3,
              32'h4, 32'h5, 1'b1, 1'b1, 1'b1, 4'h0);
          s.e = mk(0, 0, 0, 0, 4'h0, 5'd10, 5'd11, 5'd12, 32'hC, 32'h3,
                   32'h4, 32'h5);
        end
        3: begin
          drv(1'b1, 32'h10, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 32'h8000_0000,
              32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 4'h0);
          s.e = mk(1, 0, 1, 0, 4'h0, 5'd2, 5'd0, 5'd0, 32'h10, 32'h8000_0000,
                   32'h0, 32'hFFFF_FFFC);
        end
        4: begin
          drv(1'b1, 32'h14, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'h0, 32'h0,
              32'h1, 1'b1, 1'b0, 1'b0, 4'hA);
          s.e = mk(1, 1, 0, 0, 4'hA, 5'd0, 5'd0, 5'd8, 32'h14, 32'h0,
                   32'h0, 32'h1);
        end
        default: begin
          drv(1'b1, 32'hFFFF_FFFC, 5'd31, 5'd30, 5'd0, 1'b0, 1'b0,
              32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h7FF, 1'b1, 1'b0, 1'b0, 4'hF);
          s.e = mk(1, 1, 0, 0, 4'hF, 5'd31, 5'd30, 5'd0, 32'hFFFF_FFFC,
                   32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h7FF);
        end
      endcase
      s.ctrl_only = 1'b0;
      sb_q.push_back(s);
      tick();
      s = sb_q.pop_front();
      o = obs();
      n_chk++;
      if (o !== s.e) begin
        n_fail++;
        $display("FAIL load_%0d got=%h exp=%h", i, o, s.e);
      end
    end
  endtask

  task automatic test_bypass();
    sb_t s;
    ex_t o;
    idle();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin
          bus.wbRw = 1'b1; bus.wbRd = 5'd7; bus.wbData = 32'hDEAD_BEEF;
          drv(1'b1, 32'h200, 5'd3, 5'd7, 5'd9, 1'b1, 1'b1, 32'h33, 32'h0,
              32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
          s.e = mk(1, 1, 0, 0, 4'h1, 5'd3, 5'd7, 5'd9, 32'h200, 32'h33,
                   32'hDEAD_BEEF, 32'h0);
        end
        1: begin
          bus.wbRw = 1'b1; bus.wbRd = 5'd7; bus.wbData = 32'h1234_5678;
          drv(1'b1, 32'h204, 5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 32'h1, 32'h2,
              32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
          s.e = mk(1, 1, 0, 0, 4'h1, 5'd7, 5'd7, 5'd9, 32'h204, 32'h1234_5678,
                   32'h1234_5678, 32'h0);
        end
        2: begin
          bus.wbRw = 1'b1; bus.wbRd = 5'd0; bus.wbData = 32'hDEAD_BEEF;
          drv(1'b1, 32'h208, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0, 32'h55,
              32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
          s.e = mk(1, 1, 0, 0, 4'h1, 5'd0, 5'd0, 5'd9, 32'h208, 32'h0,
                   32'h55, 32'h0);
        end
        default: begin
          bus.wbRw = 1'b0; bus.wbRd = 5'd7; bus.wbData = 32'hDEAD_BEEF;
          drv(1'b1, 32'h20C, 5'd7, 5'd7, 5'd9, 1'b1, 1'b1, 32'h66, 32'h77,
              32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
          s.e = mk(1, 1, 0, 0, 4'h1, 5'd7, 5'd7, 5'd9, 32'h20C, 32'h66,
                   32'h77, 32'h0);
        end
      endcase
      s.ctrl_only = 1'b0;
      sb_q.push_back(s);
      tick();
      s = sb_q.pop_front();
      o = obs();
      n_chk++;
      if (o !== s.e) begin
        n_fail++;
        $display("FAIL bypass_%0d got=%h exp=%h", i, o, s.e);
      end
    end
    bus.wbRw = 1'b0;
  endtask

  task automatic test_stall();
    sb_t  s;
    ex_t  o;
    ex_t  held;
    idle();
    held = mk(1, 1, 0, 0, 4'h3, 5'd1, 5'd2, 5'd4, 32'h100, 32'hABCD, 32'h1234,
              32'h8);
    drv(1'b1, 32'h100, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 32'hABCD, 32'h1234,
        32'h8, 1'b1, 1'b0, 1'b0, 4'h3);
    tick();
    bus.exMemStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'h104 + 32'(i * 4), 5'd4, 5'd4, 5'd5, 1'b1, 1'b1, 32'h9,
          32'h9, 32'h9, 1'b1, 1'b1, 1'b0, 4'h7);
      #1;
      n_chk++;
      if (bus.holdIfId !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got=%b exp=1", i, bus.holdIfId);
      end
      s.e = held;
      s.ctrl_only = 1'b0;
      sb_q.push_back(s);
      tick();
      s = sb_q.pop_front();
      o = obs();
      n_chk++;
      if (o !== s.e) begin
        n_fail++;
        $display("FAIL stall_%0d got=%h exp=%h", i, o, s.e);
      end
    end
    bus.exMemStall = 1'b0;
  endtask

  task automatic test_load_use();
    sb_t s;
    ex_t o;
    idle();
    drv(1'b1, 32'h300, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h400, 32'h0,
        32'h0, 1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    drv(1'b1, 32'h304, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 32'h50, 32'h10,
        32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
    #1;
`ifdef LOAD_USE_STALL_EN
    n_chk++;
    if (bus.loadUseHazard !== 1'b1 || bus.holdIfId !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_detect got=%b%b exp=11", bus.loadUseHazard, bus.holdIfId);
    end
    s.e = '0;
    s.ctrl_only = 1'b1;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    o = obs();
    n_chk++;
    if (o[150:147] !== s.e[150:147]) begin
      n_fail++;
      $display("FAIL lu_bubble got=%b exp=%b", o[150:147], s.e[150:147]);
    end
    #1;
    n_chk++;
    if (bus.loadUseHazard !== 1'b0 || bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_release got=%b%b exp=00", bus.loadUseHazard, bus.holdIfId);
    end
`else
    n_chk++;
    if (bus.loadUseHazard !== 1'b0 || bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_off got=%b%b exp=00", bus.loadUseHazard, bus.holdIfId);
    end
`endif
    s.e = mk(1, 1, 0, 0, 4'h0, 5'd5, 5'd1, 5'd6, 32'h304, 32'h50, 32'h10, 32'h0);
    s.ctrl_only = 1'b0;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    o = obs();
    n_chk++;
    if (o !== s.e) begin
      n_fail++;
      $display("FAIL lu_add got=%h exp=%h", o, s.e);
    end
  endtask

  task automatic test_flush();
    sb_t s;
    ex_t o;
    idle();
    drv(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
        1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    drv(1'b1, 32'h504, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b0, 4'h0);
    bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.loadUseHazard !== 1'b0 || bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_comb got=%b%b exp=00", bus.loadUseHazard, bus.holdIfId);
    end
    s.e = '0;
    s.ctrl_only = 1'b1;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    o = obs();
    n_chk++;
    if (o[150:147] !== s.e[150:147]) begin
      n_fail++;
      $display("FAIL flush_ctrl got=%b exp=%b", o[150:147], s.e[150:147]);
    end
    bus.flush = 1'b0;
    drv(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
        1'b1, 1'b0, 1'b1, 4'h0);
    tick();
    bus.flush = 1'b1;
    bus.exMemStall = 1'b1;
    #1;
    n_chk++;
    if (bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall_hold got=%b exp=0", bus.holdIfId);
    end
    s.e = '0;
    s.ctrl_only = 1'b1;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    o = obs();
    n_chk++;
    if (o[150:147] !== s.e[150:147]) begin
      n_fail++;
      $display("FAIL flush_stall_ctrl got=%b exp=%b", o[150:147], s.e[150:147]);
    end
    bus.flush = 1'b0;
    bus.exMemStall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    sb_t s;
    ex_t o;
    idle();
    drv(1'b1, 32'h700, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
        1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    drv(1'b1, 32'h704, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 32'h21, 32'h22, 32'h23,
        1'b1, 1'b0, 1'b0, 4'h4);
    bus.exMemStall = 1'b1;
    #1;
    n_chk++;
    if (bus.holdIfId !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_hold got=%b exp=1", bus.holdIfId);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.exMemStall = 1'b0;
    #1;
    o = obs();
    n_chk++;
    if (o !== ex_t'(0)) begin
      n_fail++;
      $display("FAIL rst_stall_ex got=%h exp=%h", o, ex_t'(0));
    end
    n_chk++;
    if (bus.loadUseHazard !== 1'b0 || bus.holdIfId !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_comb got=%b%b exp=00", bus.loadUseHazard, bus.holdIfId);
    end
    s.e = mk(1, 1, 0, 0, 4'h4, 5'd5, 5'd1, 5'd6, 32'h704, 32'h21, 32'h22, 32'h23);
    s.ctrl_only = 1'b0;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    o = obs();
    n_chk++;
    if (o !== s.e) begin
      n_fail++;
      $display("FAIL rst_stall_next got=%h exp=%h", o, s.e);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wbRw = 1'b0; bus.wbRd = 5'd0; bus.wbData = 32'd0;
    bus.flush = 1'b0; bus.exMemStall = 1'b0;
    drv(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
        1'b0, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_load();
    test_bypass();
    test_stall();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
